// File: rtl/frame_datagram_scheduler.sv
// Frame datagram scheduler: shadow buffer filled from the core, committed to
// the shared front buffer once every enabled quadrant has entered vblank.
module frame_datagram_scheduler #(
    parameter int                MSG_W     = 32,
    parameter int                N_QUAD    = 4,
    parameter logic [N_QUAD-1:0] QUAD_MASK = {N_QUAD{1'b1}},
    parameter int                TIMEOUT   = 900000,
    parameter int                TO_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MSG_W-1:0]  in_datagram,
    input  logic [N_QUAD-1:0] vblank_pulse,
    output logic [MSG_W-1:0]  out_datagram,
    output logic              commit,
    output logic              stale,
    output logic [7:0]        stale_cnt
);

    typedef enum logic {
        EMPTY,
        PENDING
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic [MSG_W-1:0]  shadow_q, shadow_d;
    logic [MSG_W-1:0]  out_q, out_d;
    logic [N_QUAD-1:0] seen_q, seen_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic              commit_q, commit_d;
    logic              stale_q, stale_d;
    logic [7:0]        stale_cnt_q, stale_cnt_d;

    logic              ready_c;
    logic              xfer_c;
    logic              pending_c;
    logic [N_QUAD-1:0] seen_nx_c;
    logic              all_c;
    logic              to_c;
    logic              fire_c;
    logic              forced_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load on transfer, return to EMPTY on commit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (xfer_c) state_d = PENDING;
            PENDING: if (fire_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs: handshake and commit conditions
    always_comb begin
        ready_c   = (state_q == EMPTY);
        pending_c = (state_q == PENDING);
        xfer_c    = in_valid & ready_c;
        seen_nx_c = seen_q | (vblank_pulse & QUAD_MASK);
        all_c     = ((seen_nx_c & QUAD_MASK) == QUAD_MASK);
        to_c      = (timer_q == TO_LAST);
        fire_c    = pending_c & (all_c | to_c);
        forced_c  = pending_c & to_c & ~all_c;
    end

    // Datapath next values: shadow, front buffer, vblank tracking, timeout
    always_comb begin
        shadow_d    = shadow_q;
        out_d       = out_q;
        seen_d      = '0;
        timer_d     = '0;
        commit_d    = fire_c;
        stale_d     = forced_c;
        stale_cnt_d = stale_cnt_q;
        if (xfer_c) begin
            shadow_d = in_datagram;
        end
        if (fire_c) begin
            out_d = shadow_q;
        end
        if (pending_c && !fire_c) begin
            seen_d = seen_nx_c;
            if (seen_nx_c != '0) begin
                timer_d = timer_q + TO_W'(1);
            end
        end
        if (forced_c && stale_cnt_q != 8'hFF) begin
            stale_cnt_d = stale_cnt_q + 8'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            out_q       <= '0;
            seen_q      <= '0;
            timer_q     <= '0;
            commit_q    <= 1'b0;
            stale_q     <= 1'b0;
            stale_cnt_q <= 8'd0;
        end else begin
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            seen_q      <= seen_d;
            timer_q     <= timer_d;
            commit_q    <= commit_d;
            stale_q     <= stale_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign in_ready     = ready_c;
    assign out_datagram = out_q;
    assign commit       = commit_q;
    assign stale        = stale_q;
    assign stale_cnt    = stale_cnt_q;

endmodule

// File: tb/tb_frame_datagram_scheduler.sv
// Directed bench for frame_datagram_scheduler: full-mask and
// partial-mask instances driven and sampled on the falling edge.
module tb_frame_datagram_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] a_dg = '0;
    logic [3:0]  a_vb = '0;
    logic [15:0] a_out;
    logic        a_commit;
    logic        a_stale;
    logic [7:0]  a_cnt;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_dg = '0;
    logic [3:0]  b_vb = '0;
    logic [15:0] b_out;
    logic        b_commit;
    logic        b_stale;
    logic [7:0]  b_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    frame_datagram_scheduler #(
        .MSG_W(16), .N_QUAD(4), .QUAD_MASK(4'b1111),
        .TIMEOUT(100), .TO_W(20)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_datagram(a_dg),
        .vblank_pulse(a_vb), .out_datagram(a_out),
        .commit(a_commit), .stale(a_stale), .stale_cnt(a_cnt)
    );

    frame_datagram_scheduler #(
        .MSG_W(16), .N_QUAD(4), .QUAD_MASK(4'b0101),
        .TIMEOUT(100), .TO_W(20)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_datagram(b_dg),
        .vblank_pulse(b_vb), .out_datagram(b_out),
        .commit(b_commit), .stale(b_stale), .stale_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // load one datagram, pulse q0 only, wait for the forced commit
    task automatic stall_round();
        bit got;
        a_valid = 1'b1;
        a_dg = 16'h0BEE;
        tick(1);
        a_valid = 1'b0;
        a_vb = 4'b0001;
        tick(1);
        a_vb = 4'b0000;
        got = 1'b0;
        for (int i = 0; i < 150 && !got; i++) begin
            tick(1);
            if (a_commit) got = 1'b1;
        end
        chk("to_wait", 32'(got), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early;

        // reset values
        tick(2);
        chk("rst_out", a_out, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_commit", a_commit, 0);
        chk("rst_stale", a_stale, 0);
        chk("rst_cnt", a_cnt, 0);
        rst = 1'b0;

        // 1: load 0xA5, vblank q0..q3 ten cycles apart
        a_valid = 1'b1;
        a_dg = 16'h00A5;
        tick(1);
        a_valid = 1'b0;
        a_dg = 16'hFFFF;
        chk("t1_ready_low", a_ready, 0);
        chk("t1_out_hold", a_out, 0);
        for (int q = 0; q < 4; q++) begin
            tick(9);
            a_vb = 4'(1 << q);
            tick(1);
            a_vb = 4'b0000;
            if (q < 3) chk("t1_no_commit", a_commit, 0);
        end
        chk("t1_commit", a_commit, 1);
        chk("t1_out", a_out, 16'h00A5);
        chk("t1_ready", a_ready, 1);
        chk("t1_stale", a_stale, 0);
        tick(1);
        chk("t1_commit_pulse", a_commit, 0);

        // 2: vblank in the transfer cycle is not collected
        a_valid = 1'b1;
        a_dg = 16'h1234;
        a_vb = 4'b1111;
        tick(1);
        a_valid = 1'b0;
        a_vb = 4'b0000;
        chk("t2_ready_low", a_ready, 0);
        early = 1'b0;
        for (int i = 0; i < 49; i++) begin
            tick(1);
            if (a_commit) early = 1'b1;
        end
        chk("t2_no_commit", 32'(early), 0);
        chk("t2_out_hold", a_out, 16'h00A5);
        a_vb = 4'b1111;
        tick(1);
        a_vb = 4'b0000;
        chk("t2_commit", a_commit, 1);
        chk("t2_out", a_out, 16'h1234);

        // 3: q0 only -> forced commit 100 cycles after the pulse cycle
        a_valid = 1'b1;
        a_dg = 16'h0BEE;
        tick(1);
        a_valid = 1'b0;
        a_vb = 4'b0001;
        tick(1);
        a_vb = 4'b0000;
        early = 1'b0;
        for (int i = 0; i < 98; i++) begin
            tick(1);
            if (a_commit) early = 1'b1;
        end
        chk("t3_no_early", 32'(early), 0);
        tick(1);
        chk("t3_commit", a_commit, 1);
        chk("t3_stale", a_stale, 1);
        chk("t3_cnt", a_cnt, 1);
        chk("t3_out", a_out, 16'h0BEE);
        tick(1);
        chk("t3_stale_pulse", a_stale, 0);
        for (int r = 1; r < 300; r++) begin
            stall_round();
            if (r == 254) chk("t3_cnt_255", a_cnt, 255);
        end
        chk("t3_cnt_sat", a_cnt, 255);

        // 4: partial mask, q1/q3 ignored
        b_valid = 1'b1;
        b_dg = 16'h5A5A;
        tick(1);
        b_valid = 1'b0;
        tick(2);
        b_vb = 4'b0001;
        tick(1);
        b_vb = 4'b0010;
        tick(1);
        b_vb = 4'b1000;
        tick(1);
        b_vb = 4'b0000;
        tick(2);
        chk("t4_no_commit", b_commit, 0);
        chk("t4_out_hold", b_out, 0);
        b_vb = 4'b0100;
        tick(1);
        b_vb = 4'b0000;
        chk("t4_commit", b_commit, 1);
        chk("t4_out", b_out, 16'h5A5A);
        chk("t4_stale", b_stale, 0);

        // 5: reset while pending
        a_valid = 1'b1;
        a_dg = 16'h7777;
        tick(1);
        a_valid = 1'b0;
        a_vb = 4'b0001;
        tick(1);
        a_vb = 4'b0010;
        tick(1);
        a_vb = 4'b0000;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_out", a_out, 0);
        chk("t5_ready", a_ready, 1);
        chk("t5_cnt", a_cnt, 0);
        a_vb = 4'b0100;
        tick(1);
        a_vb = 4'b1000;
        tick(1);
        a_vb = 4'b0000;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (a_commit) early = 1'b1;
        end
        chk("t5_no_commit", 32'(early), 0);
        chk("t5_out_hold", a_out, 0);

        // 6: in_valid held, three vblank rounds
        a_valid = 1'b1;
        a_dg = 16'h0100;
        tick(1);
        a_dg = 16'h0101;
        for (int r = 0; r < 3; r++) begin
            a_vb = 4'b1111;
            tick(1);
            a_vb = 4'b0000;
            chk("t6_commit", a_commit, 1);
            chk("t6_out", a_out, 32'(16'h0100 + r));
            chk("t6_ready", a_ready, 1);
            tick(1);
            chk("t6_accepted", a_ready, 0);
            a_dg = 16'(16'h0102 + r);
        end
        a_valid = 1'b0;
        chk("t6_out_final", a_out, 16'h0102);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/frame_datagram_scheduler.md
Name: frame_datagram_scheduler

Overview:
- Sits between the game core and the four per-quadrant output interfaces.
- Accepts core datagrams over a valid/ready handshake into a shadow buffer.
- Commits the shadow buffer to a single front buffer that drives all quadrants, so every display switches frames only after each enabled quadrant has entered vertical blank. This prevents tearing and cross-quadrant frame skew.
- A timeout forces the commit if a quadrant stalls.

Parameters:
- MSG_W, MESSAGE_SIZE: datagram width in bits.
- N_QUAD, 4: number of quadrant output interfaces.
- QUAD_MASK, 4'b1111: quadrants whose vblank is required for a commit. Bit k=0 means quadrant k is ignored.
- TIMEOUT, 900000: cycles allowed from the first collected vblank before a forced commit.
- TO_W, 20: timeout counter width. Must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  input  1  system clock (100 MHz); the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  core presents a datagram.
- in_ready  output  1  shadow buffer can accept.
- in_datagram  input  MSG_W  datagram from core.
- vblank_pulse  input  N_QUAD  one-cycle pulse per quadrant at vsync start, already synchronised to clk.
- out_datagram  output  MSG_W  front buffer, fanned out to all output interfaces.
- commit  output  1  one-cycle pulse when the front buffer updates.
- stale  output  1  high for one cycle on a timeout-forced commit.
- stale_cnt  output  8  saturating count of forced commits.

Behaviour:
- Reset values (sync, rst high at posedge):
  - out_datagram = 0, shadow = 0.
  - in_ready = 1, commit = 0, stale = 0, stale_cnt = 0.
  - seen = 0, timer = 0, state = EMPTY.
- Reset mid-PENDING discards the shadow contents; no commit is issued.
- Handshake:
  - A transfer occurs on a cycle where in_valid and in_ready are both high. in_datagram is captured into the shadow buffer and the state moves to PENDING on the next edge.
  - in_ready = (state == EMPTY), driven from registered state.
  - in_datagram is ignored when no transfer occurs.
- FSM has 2 states: EMPTY, PENDING.
  - EMPTY:
    - vblank_pulse is ignored and seen stays 0.
    - On a transfer, go to PENDING.
  - PENDING:
    - Each cycle, seen <= seen | (vblank_pulse & QUAD_MASK).
    - A vblank in the same cycle as the transfer (state EMPTY) is not collected.
    - timer is held at 0 while seen == 0.
    - Once seen != 0, timer increments by 1 per cycle, including the cycle seen first becomes nonzero.
  - Commit condition, evaluated combinationally in PENDING:
    - all = ((seen | (vblank_pulse & QUAD_MASK)) & QUAD_MASK) == QUAD_MASK.
    - to = (timer == TIMEOUT-1).
  - When all or to holds at edge N:
    - At N+1: out_datagram <= shadow, commit = 1, seen = 0, timer = 0, state = EMPTY, in_ready = 1.
  - If to holds without all:
    - At N+1, stale = 1 and stale_cnt increments, saturating at 255.
    - If all and to hold together, the commit counts as normal: stale stays 0.
- Commit latency: 1 cycle after the final required vblank pulse.
- Repeated vblank from an already-seen quadrant has no effect and does not restart timer.
- QUAD_MASK = 0: commit on the first PENDING cycle, one cycle after the transfer.
- Throughput is at most one datagram per commit. A new transfer is possible on the commit cycle itself (in_ready = 1 at N+1).
- out_datagram changes only on commit.
- Arithmetic: timer is unsigned TO_W bits and never wraps, because a commit fires at TIMEOUT-1. stale_cnt is 8-bit saturating.

Test Plan:
1. Reset, then in_valid=1 with datagram 0xA5 (zero-extended) -> in_ready drops the next cycle; out_datagram stays 0. Pulse vblank quadrants 0,1,2,3 on separate cycles 10 apart -> commit one cycle after the q3 pulse; out_datagram = 0xA5; in_ready = 1; stale = 0.
2. All four vblank bits pulse in the same cycle the transfer is accepted -> no commit. A second full set of pulses 50 cycles later -> commit at +1.
3. TIMEOUT=100. Load a datagram, pulse q0 only -> forced commit exactly 100 cycles after the q0 pulse cycle; stale = 1 for one cycle; stale_cnt = 1. Repeat 300 times -> stale_cnt saturates at 255.
4. QUAD_MASK=4'b0101. Pulse q0, q1, q3, then q2 -> commit one cycle after q2; q1 and q3 are ignored.
5. Load datagram, pulse q0 and q1, assert rst for 1 cycle -> out_datagram = 0, in_ready = 1, seen cleared. Pulse q2 and q3 -> no commit.
6. Hold in_valid high with an incrementing datagram; run 3 full vblank rounds -> out_datagram takes exactly 3 sequential values, each accepted on the cycle after the previous commit; no datagram is lost while in_valid is held.
